// File: rtl/dq_slot_pipe.sv
// rtl/dq_slot_pipe.sv - burst-slot shift pipeline that books bursts and drives the DQ enables
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   mux_sel      one-hot slot select from the vacancy selector; all-zero = no booking
//   rw           direction of the booking (1 = write) and hint for cong
//   cmd_tag      tag carried with the booked burst
//   valid        per-slot occupancy
//   cong         per-slot "a booking here on the next edge would be rejected"
//   dq_en        slot 0 occupied
//   dq_rw        slot 0 direction, 0 when idle
//   dq_tag       slot 0 tag, 0 when idle
//   dq_first     slot 0 is the first cycle of its burst
//   dq_last      slot 0 is the last cycle of its burst
//   outstanding  number of bursts whose first cycle is still in the pipeline (saturating)
//   err_collide  sticky: booking overlapped an occupied slot or broke turnaround
//   err_sel      sticky: mux_sel not one-hot, or burst would run off the pipeline end

module dq_slot_pipe #(
  parameter int CL_max    = 10,
  parameter int BURST_CYC = 4,
  parameter int TAG_W     = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CL_max-1:0] mux_sel,
  input  logic              rw,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [CL_max-1:0] valid,
  output logic [CL_max-1:0] cong,
  output logic              dq_en,
  output logic              dq_rw,
  output logic [TAG_W-1:0]  dq_tag,
  output logic              dq_first,
  output logic              dq_last,
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_collide,
  output logic              err_sel
);

  // Extended post-shift view: bit e holds post-shift slot e-1, so the slot
  // just below index 0 and everything above CL_max-1 read as empty padding.
  localparam int EXT_W = CL_max + BURST_CYC + 1;

  logic [CL_max-1:0] occ_q, rw_q, first_q, last_q;
  logic [TAG_W-1:0]  tag_q [CL_max];
  logic [CNT_W-1:0]  out_q;
  logic              err_coll_q, err_sel_q;

  logic [CL_max-1:0] sh_occ, sh_rw, sh_first, sh_last;
  logic [TAG_W-1:0]  sh_tag [CL_max];
  logic [EXT_W-1:0]  ext_occ, ext_rw;
  logic [CL_max-1:0] range_bad, coll;
  logic [CL_max+BURST_CYC-1:0] span_ext;
  logic [CL_max-1:0] span, last_mask;
  logic              book_req, one_hot, bad_sel, bad_coll, accept, first_out;

  // Contents every slot will hold after this edge's shift, before any booking.
  assign sh_occ   = occ_q >> 1;
  assign sh_rw    = rw_q >> 1;
  assign sh_first = first_q >> 1;
  assign sh_last  = last_q >> 1;

  always_comb begin
    for (int i = 0; i < CL_max; i++) sh_tag[i] = '0;
    for (int i = 0; i < CL_max - 1; i++) sh_tag[i] = tag_q[i+1];
  end

  assign ext_occ = {{BURST_CYC{1'b0}}, sh_occ, 1'b0};
  assign ext_rw  = {{BURST_CYC{1'b0}}, sh_rw, 1'b0};

  // Per start index: does the burst fit, and would it overlap or sit next to
  // an opposite-direction burst without the one-slot turnaround gap.
  always_comb begin
    range_bad = '0;
    coll      = '0;
    for (int i = 0; i < CL_max; i++) begin
      range_bad[i] = (i + BURST_CYC > CL_max);
      coll[i] = (|ext_occ[i+1 +: BURST_CYC])
              | (ext_occ[i] & (ext_rw[i] != rw))
              | (ext_occ[i+BURST_CYC+1] & (ext_rw[i+BURST_CYC+1] != rw));
    end
  end

  // Range bits are constant, so mask cong during reset to keep all outputs low.
  assign cong = rst ? (range_bad | coll) : '0;

  always_comb begin
    span_ext = '0;
    for (int i = 0; i < CL_max; i++) begin
      if (mux_sel[i]) span_ext[i +: BURST_CYC] = '1;
    end
  end

  assign span      = span_ext[CL_max-1:0];
  assign last_mask = mux_sel << (BURST_CYC - 1);

  assign book_req = |mux_sel;
  assign one_hot  = ($countones(mux_sel) == 1);
  assign bad_sel  = book_req & (~one_hot | (|(mux_sel & range_bad)));
  assign bad_coll = book_req & ~bad_sel & (|(mux_sel & coll));
  assign accept   = book_req & ~bad_sel & ~bad_coll;

  // A burst's first cycle leaves the pipeline when slot 0 holds it at this edge.
  assign first_out = occ_q[0] & first_q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      rw_q       <= '0;
      first_q    <= '0;
      last_q     <= '0;
      out_q      <= '0;
      err_coll_q <= 1'b0;
      err_sel_q  <= 1'b0;
      for (int i = 0; i < CL_max; i++) tag_q[i] <= '0;
    end else begin
      if (accept) begin
        occ_q   <= sh_occ | span;
        rw_q    <= (sh_rw & ~span) | ({CL_max{rw}} & span);
        first_q <= (sh_first & ~span) | mux_sel;
        last_q  <= (sh_last & ~span) | last_mask;
      end else begin
        occ_q   <= sh_occ;
        rw_q    <= sh_rw;
        first_q <= sh_first;
        last_q  <= sh_last;
      end
      for (int i = 0; i < CL_max; i++) begin
        tag_q[i] <= (accept && span[i]) ? cmd_tag : sh_tag[i];
      end

      case ({accept, first_out})
        2'b10:   if (out_q != '1) out_q <= out_q + 1'b1;
        2'b01:   if (out_q != '0) out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase

      if (bad_sel)  err_sel_q  <= 1'b1;
      if (bad_coll) err_coll_q <= 1'b1;
    end
  end

  assign valid       = occ_q;
  assign dq_en       = occ_q[0];
  assign dq_rw       = occ_q[0] & rw_q[0];
  assign dq_tag      = occ_q[0] ? tag_q[0] : '0;
  assign dq_first    = occ_q[0] & first_q[0];
  assign dq_last     = occ_q[0] & last_q[0];
  assign outstanding = out_q;
  assign err_collide = err_coll_q;
  assign err_sel     = err_sel_q;

endmodule

// File: tb/tb_dq_slot_pipe.sv
// tb/tb_dq_slot_pipe.sv - scoreboard bench for dq_slot_pipe against a cycle-timeline model

module tb_dq_slot_pipe;

  localparam int CL = 10;
  localparam int BC = 4;
  localparam int TW = 4;
  localparam int CW = 4;
  localparam int HZ = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CL-1:0] mux_sel = '0;
  logic          rw = 1'b0;
  logic [TW-1:0] cmd_tag = '0;
  logic [CL-1:0] valid, cong;
  logic          dq_en, dq_rw, dq_first, dq_last, err_collide, err_sel;
  logic [TW-1:0] dq_tag;
  logic [CW-1:0] outstanding;

  dq_slot_pipe #(.CL_max(CL), .BURST_CYC(BC), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mux_sel(mux_sel), .rw(rw), .cmd_tag(cmd_tag),
    .valid(valid), .cong(cong), .dq_en(dq_en), .dq_rw(dq_rw), .dq_tag(dq_tag),
    .dq_first(dq_first), .dq_last(dq_last), .outstanding(outstanding),
    .err_collide(err_collide), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // Reference model: occupancy of the DQ bus per absolute cycle number.
  bit            m_occ   [HZ];
  bit            m_rw    [HZ];
  bit            m_first [HZ];
  bit            m_err_sel, m_err_coll;

  typedef struct {
    int            c;
    bit            d;
    logic [TW-1:0] tg;
    bit            f;
    bit            l;
  } beat_t;
  beat_t exp_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit occ_at(input int c);
    return (c >= 0 && c < HZ) ? m_occ[c] : 1'b0;
  endfunction

  function automatic bit opp_at(input int c, input bit d);
    return occ_at(c) && (m_rw[c] != d);
  endfunction

  // Would a burst booked at the edge ending cycle t, starting i cycles later, clash?
  function automatic bit would_collide(input int t, input int i, input bit d);
    int s;
    s = t + 1 + i;
    for (int b = 0; b < BC; b++) if (occ_at(s + b)) return 1'b1;
    if (i >= 1 && opp_at(s - 1, d)) return 1'b1;
    if (i + BC < CL && opp_at(s + BC, d)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < HZ; c++) begin
      m_occ[c] = 1'b0;
      m_rw[c] = 1'b0;
      m_first[c] = 1'b0;
    end
    m_err_sel = 1'b0;
    m_err_coll = 1'b0;
    exp_q.delete();
  endfunction

  // Monitor: compares DUT outputs every cycle, popping scoreboard beats on dq_en.
  always @(posedge clk) begin : mon
    logic [CL-1:0] ev, ec;
    int            oc, idx;
    #2;
    if (mon_en && rst) begin
      oc = 0;
      for (int i = 0; i < CL; i++) begin
        ev[i] = occ_at(cyc + i);
        ec[i] = (i + BC > CL) || would_collide(cyc, i, rw);
        if (occ_at(cyc + i) && m_first[cyc + i]) oc++;
      end
      if (oc > (1 << CW) - 1) oc = (1 << CW) - 1;
      chk("valid", 32'(valid), 32'(ev));
      chk("cong", 32'(cong), 32'(ec));
      chk("outstanding", 32'(outstanding), 32'(oc));
      chk("err_sel", 32'(err_sel), 32'(m_err_sel));
      chk("err_collide", 32'(err_collide), 32'(m_err_coll));
      idx = -1;
      foreach (exp_q[j]) if (exp_q[j].c == cyc) idx = j;
      if (dq_en) begin
        if (idx < 0) chk("dq_en_unexpected", 32'(1), 32'(0));
        else begin
          chk("dq_rw", 32'(dq_rw), 32'(exp_q[idx].d));
          chk("dq_tag", 32'(dq_tag), 32'(exp_q[idx].tg));
          chk("dq_first", 32'(dq_first), 32'(exp_q[idx].f));
          chk("dq_last", 32'(dq_last), 32'(exp_q[idx].l));
          exp_q.delete(idx);
        end
      end else if (idx >= 0) begin
        chk("dq_en_missing", 32'(0), 32'(1));
        exp_q.delete(idx);
      end else begin
        chk("dq_idle", 32'({dq_rw, dq_tag, dq_first, dq_last}), 32'(0));
      end
    end
  end

  // Drive one request for the next edge and book it in the model if legal.
  task automatic drive(input logic [CL-1:0] sel, input bit d, input logic [TW-1:0] tg);
    int t, k, n;
    @(negedge clk);
    mux_sel = sel;
    rw = d;
    cmd_tag = tg;
    t = cyc;
    n = $countones(sel);
    if (n == 0) return;
    if (n > 1) begin
      m_err_sel = 1'b1;
      return;
    end
    k = 0;
    for (int i = 0; i < CL; i++) if (sel[i]) k = i;
    if (k + BC > CL) begin
      m_err_sel = 1'b1;
      return;
    end
    if (would_collide(t, k, d)) begin
      m_err_coll = 1'b1;
      return;
    end
    for (int b = 0; b < BC; b++) begin
      int c;
      c = t + 1 + k + b;
      m_occ[c] = 1'b1;
      m_rw[c] = d;
      m_first[c] = (b == 0);
      exp_q.push_back('{c, d, tg, (b == 0), (b == BC - 1)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, rw, '0);
  endtask

  task automatic book(input int k, input bit d, input logic [TW-1:0] tg);
    logic [CL-1:0] s;
    s = '0;
    s[k] = 1'b1;
    drive(s, d, tg);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'(0));
    chk({tag, "_cong"}, 32'(cong), 32'(0));
    chk({tag, "_dq"}, 32'({dq_en, dq_rw, dq_tag, dq_first, dq_last}), 32'(0));
    chk({tag, "_outstanding"}, 32'(outstanding), 32'(0));
    chk({tag, "_errs"}, 32'({err_sel, err_collide}), 32'(0));
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b0;
    mux_sel = '0;
    #1;
    check_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [CL-1:0] s;
    model_clear();
    #1;
    check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    check_all_zero("por_hold");
    rst = 1'b1;
    mon_en = 1'b1;

    book(3, 1'b1, 4'd5);
    idle(10);

    book(2, 1'b0, 4'd3);
    book(5, 1'b0, 4'd4);
    idle(10);

    book(2, 1'b1, 4'd1);
    book(5, 1'b0, 4'd2);
    book(6, 1'b0, 4'd2);
    idle(10);

    drive(10'b0000100100, 1'b0, 4'd8);
    book(7, 1'b0, 4'd8);
    idle(3);

    book(4, 1'b0, 4'd6);
    idle(6);

    book(0, 1'b1, 4'd7);
    reset_mid();
    book(0, 1'b0, 4'd9);
    idle(6);

    for (int it = 0; it < 1500; it++) begin
      int r;
      if (it == 750) reset_mid();
      r = $urandom_range(0, 99);
      if (r < 45) s = '0;
      else if (r < 88) begin
        s = '0;
        s[$urandom_range(0, CL - 1)] = 1'b1;
      end else s = CL'($urandom());
      drive(s, 1'($urandom()), TW'($urandom()));
    end

    idle(15);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
